// File: rtl/twowire_dtm_serial_if.sv
// Signal bundle between the two-wire serial link layer, the host data line and the DTM core.
// The slave modport is the link layer; the master modport is its environment.
interface twowire_dtm_serial_if #(
  parameter int W_CMD = 4
);
  logic             di_i;
  logic             do_o;
  logic             doe_o;
  logic             connected_o;
  logic             disconnect_now_i;
  logic [3:0]       mdropaddr_i;
  logic [W_CMD-1:0] cmd_o;
  logic             cmd_vld_o;
  logic             cmd_payload_end_i;
  logic             serial_parity_err_o;
  logic             serial_wdata_o;
  logic             serial_wdata_vld_o;
  logic             serial_rdata_i;
  logic             serial_rdata_rdy_o;

  // Handshake: serial_wdata_o is a payload bit only in cycles with serial_wdata_vld_o=1;
  // serial_rdata_i is consumed in every cycle with serial_rdata_rdy_o=1 (no back-pressure);
  // cmd_payload_end_i is looked at only in those payload cycles, disconnect_now_i only with cmd_vld_o.
  modport slave (
    input  di_i, disconnect_now_i, mdropaddr_i, cmd_payload_end_i, serial_rdata_i,
    output do_o, doe_o, connected_o, cmd_o, cmd_vld_o, serial_parity_err_o,
    output serial_wdata_o, serial_wdata_vld_o, serial_rdata_rdy_o
  );

  modport master (
    output di_i, disconnect_now_i, mdropaddr_i, cmd_payload_end_i, serial_rdata_i,
    input  do_o, doe_o, connected_o, cmd_o, cmd_vld_o, serial_parity_err_o,
    input  serial_wdata_o, serial_wdata_vld_o, serial_rdata_rdy_o
  );
endinterface

// File: rtl/twowire_dtm_serial.sv
// Two-wire DTM serial link layer: connect detection, command framing with parity,
// write payload streaming into the core and read payload streaming back onto the line.
module twowire_dtm_serial #(
  parameter int          W_CMD         = 4,
  parameter logic [31:0] CONNECT_MAGIC = 32'hd1a5c3e7
) (
  input  logic                dck,
  input  logic                drst_n,
  twowire_dtm_serial_if.slave bus,
  output logic [3:0]          dbg_state_o
);

  typedef enum logic [3:0] {
    S_DISC, S_IDLE, S_CMD, S_CPAR, S_WDATA, S_WPAR, S_TURN1, S_RDATA, S_RPAR, S_TURN2
  } state_e;

  localparam int CNT_W = $clog2(W_CMD + 1);

  state_e           state_q, state_d;
  logic [35:0]      shift_q, shift_d;
  logic [W_CMD-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             do_q, do_d;
  logic             doe_q, doe_d;

  logic             cmd_vld;
  logic             parity_err;
  logic             wdata_vld;
  logic             rdata_rdy;
  logic             is_write;
  logic             cpar_ok;

  assign is_write = (cmd_q == W_CMD'(3)) || (cmd_q == W_CMD'(5)) || (cmd_q == W_CMD'(9));
  // Even parity across the command bits together with the parity bit now on di.
  assign cpar_ok  = ~(^{cmd_q, bus.di_i});

  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state_q   <= S_DISC;
      shift_q   <= '0;
      cmd_q     <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      do_q      <= 1'b0;
      doe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      do_q      <= do_d;
      doe_q     <= doe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = '0;
    cmd_d      = cmd_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    do_d       = 1'b0;
    doe_d      = 1'b0;
    cmd_vld    = 1'b0;
    parity_err = 1'b0;
    wdata_vld  = 1'b0;
    rdata_rdy  = 1'b0;

    unique case (state_q)
      S_DISC: begin
        // The bit on di during the match cycle is dropped; the shifter restarts from zero.
        if (shift_q == {CONNECT_MAGIC, bus.mdropaddr_i}) state_d = S_IDLE;
        else shift_d = {shift_q[34:0], bus.di_i};
      end
      S_IDLE: begin
        if (bus.di_i) begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
        end
      end
      S_CMD: begin
        cmd_d     = {cmd_q[W_CMD-2:0], bus.di_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(W_CMD - 1)) state_d = S_CPAR;
      end
      S_CPAR: begin
        if (cpar_ok) begin
          cmd_vld = 1'b1;
          par_d   = 1'b0;
          if (bus.disconnect_now_i) state_d = S_DISC;
          else if (is_write)        state_d = S_WDATA;
          else                      state_d = S_TURN1;
        end else begin
          parity_err = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WDATA: begin
        wdata_vld = 1'b1;
        par_d     = par_q ^ bus.di_i;
        if (bus.cmd_payload_end_i) state_d = S_WPAR;
      end
      S_WPAR: begin
        parity_err = (bus.di_i != par_q);
        state_d    = S_IDLE;
      end
      S_TURN1: begin
        par_d   = 1'b0;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        rdata_rdy = 1'b1;
        doe_d     = 1'b1;
        do_d      = bus.serial_rdata_i;
        par_d     = par_q ^ bus.serial_rdata_i;
        if (bus.cmd_payload_end_i) state_d = S_RPAR;
      end
      S_RPAR: begin
        doe_d   = 1'b1;
        do_d    = par_q;
        state_d = S_TURN2;
      end
      S_TURN2: state_d = S_IDLE;
      default: state_d = S_DISC;
    endcase
  end

  assign bus.do_o                = do_q;
  assign bus.doe_o               = doe_q;
  assign bus.connected_o         = (state_q != S_DISC);
  assign bus.cmd_o               = cmd_q;
  assign bus.cmd_vld_o           = cmd_vld;
  assign bus.serial_parity_err_o = parity_err;
  assign bus.serial_wdata_o      = bus.di_i;
  assign bus.serial_wdata_vld_o  = wdata_vld;
  assign bus.serial_rdata_rdy_o  = rdata_rdy;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_twowire_dtm_serial.sv
// Bench for twowire_dtm_serial: a host driver and a 32-bit-payload core model feed a
// scoreboard of link events (command, parity error, payload words, connect changes).
module tb_twowire_dtm_serial;
  localparam int          W_CMD = 4;
  localparam logic [31:0] MAGIC = 32'hd1a5c3e7;
  localparam int          EW    = 44;
  localparam logic [3:0]  EV_CMD = 4'd1, EV_PERR = 4'd2, EV_WR = 4'd3, EV_RD = 4'd4, EV_CONN = 4'd5;

  // ---------------- clock / reset ----------------
  logic dck    = 1'b0;
  logic drst_n = 1'b0;
  always #5 dck = ~dck;

  logic [3:0] dbg_state;
  twowire_dtm_serial_if #(.W_CMD(W_CMD)) bus ();

  twowire_dtm_serial #(.W_CMD(W_CMD), .CONNECT_MAGIC(MAGIC)) dut (
    .dck         (dck),
    .drst_n      (drst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- core model: every payload is 32 bits ----------------
  logic        di       = 1'b0;
  logic        disc_req = 1'b0;
  logic [3:0]  addr     = 4'h0;
  logic [31:0] rd_word  = 32'h0;
  logic [5:0]  pay_cnt;

  assign bus.di_i              = di;
  assign bus.mdropaddr_i       = addr;
  assign bus.disconnect_now_i  = disc_req;
  assign bus.cmd_payload_end_i = (bus.serial_wdata_vld_o || bus.serial_rdata_rdy_o) && (pay_cnt == 6'd31);
  assign bus.serial_rdata_i    = rd_word[5'd31 - pay_cnt[4:0]];

  always @(posedge dck or negedge drst_n) begin
    if (!drst_n)                                           pay_cnt <= 6'd0;
    else if (bus.cmd_vld_o)                                pay_cnt <= 6'd0;
    else if (bus.serial_wdata_vld_o || bus.serial_rdata_rdy_o) pay_cnt <= pay_cnt + 6'd1;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  done   = 1'b0;

  function automatic logic [EW-1:0] ev(input logic [3:0] k, input logic [6:0] n, input logic [32:0] d);
    return {k, n, d};
  endfunction

  task automatic observe(input logic [EW-1:0] got, input string name);
    logic [EW-1:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event %h, required no event", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got event %h, required %h", name, got, want);
      end
    end
  endtask

  logic [32:0] wacc = '0, racc = '0;
  int          wn = 0, rn = 0;
  logic        conn_prev = 1'b0;

  always @(negedge dck) begin
    if (!drst_n) begin
      checks++;
      if ({bus.do_o, bus.doe_o, bus.connected_o, bus.cmd_o, bus.cmd_vld_o, bus.serial_parity_err_o,
           bus.serial_wdata_vld_o, bus.serial_rdata_rdy_o} !== 12'b0) begin
        errors++;
        $display("FAIL reset_values: got do/doe/conn/cmd/vld/perr/wvld/rdy=%b, required all zero",
                 {bus.do_o, bus.doe_o, bus.connected_o, bus.cmd_o, bus.cmd_vld_o,
                  bus.serial_parity_err_o, bus.serial_wdata_vld_o, bus.serial_rdata_rdy_o});
      end
      wacc = '0; racc = '0; wn = 0; rn = 0; conn_prev = 1'b0;
    end else begin
      if (bus.serial_wdata_vld_o) begin
        wacc = {wacc[31:0], bus.serial_wdata_o};
        wn++;
      end else if (wn != 0) begin
        observe(ev(EV_WR, 7'(wn), wacc), "write_payload");
        wacc = '0; wn = 0;
      end
      if (bus.doe_o) begin
        racc = {racc[31:0], bus.do_o};
        rn++;
      end else if (rn != 0) begin
        observe(ev(EV_RD, 7'(rn), racc), "read_payload");
        racc = '0; rn = 0;
      end
      if (bus.cmd_vld_o)           observe(ev(EV_CMD, 7'd0, {29'b0, bus.cmd_o}), "cmd_strobe");
      if (bus.serial_parity_err_o) observe(ev(EV_PERR, 7'd0, 33'b0), "parity_err");
      if (bus.connected_o !== conn_prev) begin
        observe(ev(EV_CONN, 7'd0, {32'b0, bus.connected_o}), "connected");
        conn_prev = bus.connected_o;
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: got %0d unmatched, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- host driver tasks ----------------
  task automatic send_bit(input logic b);
    di = b;
    @(posedge dck);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_connect(input logic [3:0] a, input bit expect_conn);
    logic [35:0] s;
    s = {MAGIC, a};
    if (expect_conn) exp_q.push_back(ev(EV_CONN, 7'd0, 33'd1));
    for (int i = 35; i >= 0; i--) send_bit(s[i]);
    idle(3);
  endtask

  task automatic do_frame(input logic [3:0] c, input bit bad_cpar, input logic [31:0] data,
                          input bit bad_ppar, input bit disc);
    logic cp;
    bit   wr;
    cp = (^c) ^ bad_cpar;
    wr = (c == 4'd3) || (c == 4'd5) || (c == 4'd9);
    if (bad_cpar) exp_q.push_back(ev(EV_PERR, 7'd0, 33'b0));
    else begin
      exp_q.push_back(ev(EV_CMD, 7'd0, {29'b0, c}));
      if (disc) exp_q.push_back(ev(EV_CONN, 7'd0, 33'd0));
      else if (wr) begin
        exp_q.push_back(ev(EV_WR, 7'd32, {1'b0, data}));
        if (bad_ppar) exp_q.push_back(ev(EV_PERR, 7'd0, 33'b0));
      end else begin
        rd_word = data;
        exp_q.push_back(ev(EV_RD, 7'd33, {data, ^data}));
      end
    end
    disc_req = disc;
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(c[i]);
    send_bit(cp);
    disc_req = 1'b0;
    if (!bad_cpar && !disc) begin
      if (wr) begin
        for (int i = 31; i >= 0; i--) send_bit(data[i]);
        send_bit((^data) ^ bad_ppar);
      end else begin
        idle(36);
      end
    end
    idle(2 + $urandom_range(0, 3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] c;
    drst_n = 1'b0;
    idle(3);
    drst_n = 1'b1;
    idle(2);

    // Connect with matching address, then drop and retry with a wrong address.
    addr = 4'h0;
    send_connect(4'h0, 1'b1);
    do_frame(4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    addr = 4'h5;
    send_connect(4'h0, 1'b0);
    idle(4);
    send_connect(4'h5, 1'b1);

    // Writes with good and corrupted payload parity; IDCODE-style read.
    do_frame(4'h3, 1'b0, 32'hcafe_f00d, 1'b0, 1'b0);
    do_frame(4'h3, 1'b0, 32'h0123_4567, 1'b1, 1'b0);
    do_frame(4'h1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

    // Command parity error, then a clean frame.
    do_frame(4'h1, 1'b1, 32'h0, 1'b0, 1'b0);
    do_frame(4'h1, 1'b0, 32'hffff_ffff, 1'b0, 1'b0);

    // Disconnect; start bits must be ignored until the magic is resent.
    do_frame(4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); end
    idle(3);
    send_connect(4'h5, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      c = 4'($urandom_range(0, 15));
      do_frame(c, ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        do_frame(4'($urandom_range(0, 15)), 1'b0, 32'h0, 1'b0, 1'b1);
        send_connect(4'h5, 1'b1);
      end
    end

    // Reset while the read payload is on the line.
    exp_q.push_back(ev(EV_CMD, 7'd0, {29'b0, 4'h2}));
    rd_word = $urandom;
    send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b1);
    idle(12);
    drst_n = 1'b0;
    idle(3);
    drst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); end
    idle(3);
    send_connect(4'h5, 1'b1);
    do_frame(4'h7, 1'b0, 32'h8000_0001, 1'b0, 1'b0);

    idle(5);
    done = 1'b1;
  end

endmodule
